regfile_wb: RTL and testbench



---
 rtl/riscv_pkg.sv | 7 +
 rtl/wb_mux.sv | 12 +
 rtl/regfile_wb.sv | 64 ++++++
 tb/tb_regfile_wb.sv | 114 +++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core widths and register-file constants
package riscv_pkg;
   localparam int XLEN = 32;
   localparam int NREGS = 32;
   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/wb_mux.sv
// wb_mux: selects the writeback value from load data or ALU result
module wb_mux #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] read_data42,
   input  logic [XLEN-1:0] alu_out42,
   input  logic            memtoreg42,
   output logic [XLEN-1:0] wb_data
);
   // pure select; also feeds forwarding and the write-through path
   always_comb wb_data = memtoreg42 ? read_data42 : alu_out42;
endmodule

// File: rtl/regfile_wb.sv
// regfile_wb: writeback stage, 31-entry register file (x0 hardwired), commit counter; REGFILE_BYPASS_EN enables write-through reads
module regfile_wb #(
   parameter int XLEN = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] read_data42,
   input  logic [XLEN-1:0] alu_out42,
   input  logic            memtoreg42,
   input  logic            wr_en42,
   input  logic [4:0]      write_reg42,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic [XLEN-1:0] wb_data,
   output logic [31:0]     wb_count
);
   import riscv_pkg::*;
   logic [XLEN-1:0] regs_q [1:NREGS-1];
   logic [XLEN-1:0] regs_d [1:NREGS-1];
   logic [31:0]     wb_count_q, wb_count_d;
   logic            wr_hit;
   logic            commit;
   wb_mux #(.XLEN(XLEN)) u_wb_mux (
      .read_data42 (read_data42),
      .alu_out42   (alu_out42),
      .memtoreg42  (memtoreg42),
      .wb_data     (wb_data)
   );
   // a write targeting x0 is dropped; reset overrides any commit
   always_comb begin
      wr_hit = wr_en42 && (write_reg42 != ZERO_REG);
      commit = wr_hit && !rst;
      regs_d = regs_q;
      wb_count_d = wb_count_q;
      if (commit) begin
         regs_d[write_reg42] = wb_data;
         wb_count_d = wb_count_q + 32'd1;
      end
   end
   // register array and commit counter state
   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q <= '{default: '0};
         wb_count_q <= '0;
      end else begin
         regs_q <= regs_d;
         wb_count_q <= wb_count_d;
      end
   end
   // asynchronous read ports; x0 always reads zero
   always_comb begin
`ifdef REGFILE_BYPASS_EN
      rs1_data = (rs1_addr == ZERO_REG) ? '0 : (wr_hit && rs1_addr == write_reg42) ? wb_data : regs_q[rs1_addr];
      rs2_data = (rs2_addr == ZERO_REG) ? '0 : (wr_hit && rs2_addr == write_reg42) ? wb_data : regs_q[rs2_addr];
`else
      rs1_data = (rs1_addr == ZERO_REG) ? '0 : regs_q[rs1_addr];
      rs2_data = (rs2_addr == ZERO_REG) ? '0 : regs_q[rs2_addr];
`endif
   end
   assign wb_count = wb_count_q;
endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: directed and random checks of regfile_wb against an array model
module tb_regfile_wb;
   logic        clk, rst, memtoreg42, wr_en42;
   logic [31:0] read_data42, alu_out42;
   logic [4:0]  write_reg42, rs1_addr, rs2_addr;
   logic [31:0] rs1_data, rs2_data, wb_data, wb_count;
   logic [31:0] mdl [32];
   logic [31:0] cnt;
   int          checks = 0;
   int          errors = 0;
   regfile_wb dut (
      .clk         (clk),
      .rst         (rst),
      .read_data42 (read_data42),
      .alu_out42   (alu_out42),
      .memtoreg42  (memtoreg42),
      .wr_en42     (wr_en42),
      .write_reg42 (write_reg42),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .rs1_data    (rs1_data),
      .rs2_data    (rs2_data),
      .wb_data     (wb_data),
      .wb_count    (wb_count)
   );
   initial clk = 0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic logic [31:0] exp_rd(input logic [4:0] a, input logic w, input logic [4:0] wr, input logic [31:0] v);
      if (a == 0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
      if (w && wr != 0 && wr == a) return v;
`endif
      return mdl[a];
   endfunction
   // drive one cycle from a negedge, check combinational outputs, then advance the model at the edge
   task automatic step(input logic r, input logic w, input logic m, input logic [4:0] wr, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [31:0] rd, input logic [31:0] alu);
      logic [31:0] v;
      rst = r; wr_en42 = w; memtoreg42 = m; write_reg42 = wr;
      rs1_addr = a1; rs2_addr = a2; read_data42 = rd; alu_out42 = alu;
      v = m ? rd : alu;
      #1;
      chk("wb_data", wb_data, v);
      chk("rs1_data", rs1_data, exp_rd(a1, w, wr, v));
      chk("rs2_data", rs2_data, exp_rd(a2, w, wr, v));
      chk("wb_count", wb_count, cnt);
      @(posedge clk);
      if (r) begin
         foreach (mdl[i]) mdl[i] = 0;
         cnt = 0;
      end else if (w && wr != 0) begin
         mdl[wr] = v;
         cnt = cnt + 1;
      end
      @(negedge clk);
   endtask
   initial begin
      rst = 1; wr_en42 = 1; memtoreg42 = 0; write_reg42 = 5'd4;
      rs1_addr = 0; rs2_addr = 0; read_data42 = 0; alu_out42 = 32'h55;
      @(posedge clk);
      @(negedge clk);
      foreach (mdl[i]) mdl[i] = 0;
      cnt = 0;
      for (int i = 0; i < 32; i++)
         step(0, 0, 0, 5'(i), 5'(i), 5'(31 - i), $urandom, $urandom);
      step(0, 1, 0, 5, 0, 0, $urandom, 32'hDEADBEEF);
      wr_en42 = 0; rs1_addr = 5; #1;
      chk("x5_read", rs1_data, 32'hDEADBEEF);
      chk("count_1", wb_count, 32'd1);
      step(0, 1, 1, 6, 5, 0, 32'h12345678, $urandom);
      wr_en42 = 0; rs2_addr = 6; #1;
      chk("x6_read", rs2_data, 32'h12345678);
      chk("count_2", wb_count, 32'd2);
      step(0, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wr_en42 = 0; rs1_addr = 0; #1;
      chk("x0_read", rs1_data, 32'd0);
      chk("x0_count", wb_count, 32'd2);
      step(0, 1, 0, 7, 0, 0, $urandom, 32'h1);
      wr_en42 = 1; write_reg42 = 7; memtoreg42 = 0; alu_out42 = 32'h2; rs1_addr = 7; #1;
`ifdef REGFILE_BYPASS_EN
      chk("same_cycle", rs1_data, 32'h2);
`else
      chk("same_cycle", rs1_data, 32'h1);
`endif
      step(0, 1, 0, 7, 7, 7, $urandom, 32'h2);
      wr_en42 = 0; rs1_addr = 7; #1;
      chk("next_cycle", rs1_data, 32'h2);
      step(1, 1, 0, 3, 3, 7, $urandom, 32'hAA);
      wr_en42 = 0; rs1_addr = 3; rs2_addr = 7; #1;
      chk("rst_x3", rs1_data, 32'd0);
      chk("rst_x7", rs2_data, 32'd0);
      chk("rst_count", wb_count, 32'd0);
      for (int i = 0; i < 300; i++)
         step(($urandom_range(0, 31) == 0), 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), $urandom, $urandom);
      force dut.wb_count_q = 32'hFFFFFFFF;
      #1;
      chk("forced_count", wb_count, 32'hFFFFFFFF);
      release dut.wb_count_q;
      cnt = 32'hFFFFFFFF;
      step(0, 1, 0, 9, 0, 0, $urandom, 32'h99);
      wr_en42 = 0; #1;
      chk("wrap_count", wb_count, 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
